// File: rtl/riscv_defs_pkg.sv
// Shared RV32I/RV64I encodings used by the MEM->WB boundary.
// Write-back source selects and load funct3 values.
package riscv_defs_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction (byte/half/word, signed/unsigned).
// Misaligned offsets are not checked here.
module load_extract
  import riscv_defs_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OW   = (XLEN == 64) ? 3 : 2
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OW-1:0]   off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  always_comb begin
    b = 8'(rdata >> {off, 3'b000});
    h = 16'(rdata >> {off[OW-1:1], 4'b0000});
    // only RV64 has a second word lane
    w = 32'(rdata >> ((XLEN == 64) ? {off[OW-1], 5'b00000} : 6'd0));
    value = rdata;
    unique case (funct3)
      F3_LB:   value = XLEN'($signed(b));
      F3_LBU:  value = XLEN'(b);
      F3_LH:   value = XLEN'($signed(h));
      F3_LHU:  value = XLEN'(h);
      F3_LW:   value = XLEN'($signed(w));
      F3_LWU:  value = (XLEN == 64) ? XLEN'(w) : rdata;
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/pipe_reg_en.sv
// Enable/clear pipeline register with async active-low reset.
// Clear beats enable; enable low holds.
module pipe_reg_en #(
  parameter int         W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline boundary with stall/flush, result select
// and load extraction feeding the register file.
module mem_wb_stage
  import riscv_defs_pkg::*;
#(
  parameter int   XLEN        = XLEN_DEF,
  parameter int   REG_AW      = 5,
  parameter logic RESET_VALID = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic [1:0]        result_src_m,
  input  logic [2:0]        funct3_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   read_data_m,
  input  logic [XLEN-1:0]   pc_plus4_m,
  input  logic [REG_AW-1:0] rd_m,
  output logic              valid_w,
  output logic [REG_AW-1:0] rd_w,
  output logic              reg_write_w,
  output logic [XLEN-1:0]   result_w,
  output logic [XLEN-1:0]   alu_result_w,
  output logic [XLEN-1:0]   pc_plus4_w,
  output logic [XLEN-1:0]   read_data_w
);

  localparam int OW = (XLEN == 64) ? 3 : 2;
  localparam int CW = 1 + 2 + 3 + REG_AW;
  localparam int DW = 3 * XLEN;

  logic              reg_write_r;
  logic [1:0]        result_src_r;
  logic [2:0]        funct3_r;
  logic [XLEN-1:0]   load_val;
  logic              load_en;

  assign load_en = ~stall_w;

  pipe_reg_en #(.W(1), .RST(RESET_VALID)) u_valid (
    .clk   (Clk),
    .rst_n (Rst_n),
    .en    (load_en),
    .clr   (flush_w),
    .d     (valid_m),
    .q     (valid_w)
  );

  pipe_reg_en #(.W(CW)) u_ctrl (
    .clk   (Clk),
    .rst_n (Rst_n),
    .en    (load_en),
    .clr   (flush_w),
    .d     ({reg_write_m, result_src_m, funct3_m, rd_m}),
    .q     ({reg_write_r, result_src_r, funct3_r, rd_w})
  );

  // a flush leaves data fields intact so forwarding sees stable values
  pipe_reg_en #(.W(DW)) u_data (
    .clk   (Clk),
    .rst_n (Rst_n),
    .en    (load_en & ~flush_w),
    .clr   (1'b0),
    .d     ({alu_result_m, read_data_m, pc_plus4_m}),
    .q     ({alu_result_w, read_data_w, pc_plus4_w})
  );

  load_extract #(.XLEN(XLEN), .OW(OW)) u_ld (
    .rdata  (read_data_w),
    .off    (alu_result_w[OW-1:0]),
    .funct3 (funct3_r),
    .value  (load_val)
  );

  assign reg_write_w = valid_w & reg_write_r & (rd_w != '0);

  always_comb begin
    unique case (result_src_r)
      RESULT_LOAD: result_w = load_val;
      RESULT_PC4:  result_w = pc_plus4_w;
      default:     result_w = alu_result_w;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a behavioural model.
// Directed cases cover reset, loads, link, stall, flush, async reset.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        stall_w, flush_w, valid_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        valid_w, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w, alu_result_w, pc_plus4_w, read_data_w;

  int checks = 0;
  int errors = 0;

  // reference state: the instruction currently sitting in WB
  bit          m_valid, m_rw;
  bit [1:0]    m_src;
  bit [2:0]    m_f3;
  bit [4:0]    m_rd;
  bit [31:0]   m_alu, m_rdata, m_pc;

  always #5 Clk = ~Clk;

  mem_wb_stage dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .stall_w      (stall_w),
    .flush_w      (flush_w),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .result_src_m (result_src_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .read_data_m  (read_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .rd_m         (rd_m),
    .valid_w      (valid_w),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .result_w     (result_w),
    .alu_result_w (alu_result_w),
    .pc_plus4_w   (pc_plus4_w),
    .read_data_w  (read_data_w)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_load(bit [31:0] d, int off, bit [2:0] f3);
    int unsigned bt = (d >> (8 * off)) & 32'hFF;
    int unsigned hw = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return bt - ((bt >= 128) ? 32'd256 : 32'd0);
      3'd4:    return bt;
      3'd1:    return hw - ((hw >= 32768) ? 32'd65536 : 32'd0);
      3'd5:    return hw;
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] ref_result();
    case (m_src)
      2'd1:    return ref_load(m_rdata, int'(m_alu % 4), m_f3);
      2'd2:    return m_pc;
      default: return m_alu;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
    m_alu = 0; m_rdata = 0; m_pc = 0;
  endtask

  task automatic drive(bit v, bit rw, bit [1:0] src, bit [2:0] f3,
                       bit [31:0] alu, bit [31:0] rdata,
                       bit [31:0] pc, bit [4:0] rd);
    valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3;
    alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc; rd_m = rd;
  endtask

  // one rising edge; model follows the flush > stall > load rules
  task automatic tick();
    @(posedge Clk);
    if (Rst_n) begin
      if (flush_w) begin
        m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
      end else if (!stall_w) begin
        m_valid = valid_m; m_rw = reg_write_m; m_src = result_src_m;
        m_f3 = funct3_m; m_rd = rd_m; m_alu = alu_result_m;
        m_rdata = read_data_m; m_pc = pc_plus4_m;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, valid_w}, {31'd0, m_valid});
    check({tag, ".rd"}, {27'd0, rd_w}, {27'd0, m_rd});
    check({tag, ".we"}, {31'd0, reg_write_w},
          {31'd0, m_valid && m_rw && m_rd != 0});
    check({tag, ".result"}, result_w, ref_result());
    check({tag, ".alu"}, alu_result_w, m_alu);
    check({tag, ".pc4"}, pc_plus4_w, m_pc);
    check({tag, ".rdata"}, read_data_w, m_rdata);
  endtask

  bit [31:0] ld_addr [6] = '{0, 3, 2, 2, 0, 0};
  bit [2:0]  ld_f3   [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  bit [31:0] ld_exp  [6] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_00FF,
                             32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    Rst_n = 0; stall_w = 0; flush_w = 0;
    drive(1, 1, 2'd1, 3'd2, $urandom, $urandom, $urandom, 5'd9);
    model_reset();
    tick();
    tick();
    check("rst.valid", {31'd0, valid_w}, 32'd0);
    check("rst.we", {31'd0, reg_write_w}, 32'd0);
    check("rst.result", result_w, 32'd0);
    check("rst.rd", {27'd0, rd_w}, 32'd0);
    Rst_n = 1;

    drive(1, 1, 2'd0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd17);
    tick();
    check("first.rd", {27'd0, rd_w}, 32'd17);
    check("first.result", result_w, 32'h1234);
    check("first.we", {31'd0, reg_write_w}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2'd1, ld_f3[i], ld_addr[i], 32'h80FF_7F01, 32'd4, 5'd3);
      tick();
      check($sformatf("load%0d", i), result_w, ld_exp[i]);
      check_all($sformatf("load%0d", i));
    end

    drive(1, 1, 2'd2, 3'd0, 32'hDEAD_0000, 32'd0, 32'h0000_0104, 5'd1);
    tick();
    check("link.result", result_w, 32'h104);
    check("link.we", {31'd0, reg_write_w}, 32'd1);
    rd_m = 5'd0;
    tick();
    check("link_x0.we", {31'd0, reg_write_w}, 32'd0);
    check("link_x0.result", result_w, 32'h104);

    drive(1, 1, 2'd1, 3'd0, 32'h0000_0103, 32'h80FF_7F01, 32'h0, 5'd6);
    tick();
    check("stallA.result", result_w, 32'hFFFF_FF80);
    stall_w = 1;
    drive(1, 1, 2'd0, 3'd0, 32'h0000_BBBB, 32'h1, 32'h2, 5'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.result", i), result_w, 32'hFFFF_FF80);
      check($sformatf("stall%0d.rd", i), {27'd0, rd_w}, 32'd6);
      check_all($sformatf("stall%0d", i));
    end
    stall_w = 0;
    tick();
    check("stallB.result", result_w, 32'h0000_BBBB);
    check("stallB.rd", {27'd0, rd_w}, 32'd7);

    stall_w = 1; flush_w = 1;
    drive(1, 1, 2'd0, 3'd0, 32'h0000_CCCC, 32'h1, 32'h2, 5'd8);
    tick();
    check("flush.valid", {31'd0, valid_w}, 32'd0);
    check("flush.rd", {27'd0, rd_w}, 32'd0);
    check("flush.we", {31'd0, reg_write_w}, 32'd0);
    check("flush.alu", alu_result_w, 32'h0000_BBBB);
    check_all("flush");
    stall_w = 0; flush_w = 0;

    for (int i = 0; i < 400; i++) begin
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      tick();
      check_all("rand");
    end

    stall_w = 0; flush_w = 0;
    drive(1, 1, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 5'd12);
    tick();
    check("pre_arst.we", {31'd0, reg_write_w}, 32'd1);
    stall_w = 1;
    #2 Rst_n = 0;
    #1;
    check("arst.we", {31'd0, reg_write_w}, 32'd0);
    check("arst.valid", {31'd0, valid_w}, 32'd0);
    check("arst.alu", alu_result_w, 32'd0);
    model_reset();
    #1 Rst_n = 1;
    stall_w = 0;
    tick();
    check_all("post_arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
